reg_bank_mp: RTL and testbench

//  Parametrised, multi-write-port successor to the CPU register bank.

---
 rtl/reg_bank_mp_if.sv | 62 ++++++
 rtl/reg_bank_mp.sv | 126 ++++++++++++
 tb/tb_reg_bank_mp.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_mp_if
// Brief    : Read, write, scoreboard and status bundle of the multi-port bank.
// Revision : 1.0  initial release
// ============================================================================
interface reg_bank_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 4
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [ADDR_W-1:0] rd_a_sel;
    logic [ADDR_W-1:0] rd_b_sel;
    logic              rd_b_en;
    logic [ADDR_W-1:0] rd_c_sel;
    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_c_data;

    logic              w0_en;
    logic [ADDR_W-1:0] w0_sel;
    logic [DATA_W-1:0] w0_data;
    logic              w0_link;
    logic              w1_en;
    logic [ADDR_W-1:0] w1_sel;
    logic [DATA_W-1:0] w1_data;

    logic              pc_wr_en;
    logic [DATA_W-1:0] pc_wr_data;
    logic              flag_wr_en;
    logic [FLAG_W-1:0] flag_wr_data;
    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_sel;

    logic [DATA_W-1:0] pc_data;
    logic [FLAG_W-1:0] flag_data;
    logic              hazard;
    logic [NREGS-1:0]  pending;
    logic [DATA_W-1:0] debug_out;

    modport master (
        output rd_a_sel, rd_b_sel, rd_b_en, rd_c_sel,
        output w0_en, w0_sel, w0_data, w0_link,
        output w1_en, w1_sel, w1_data,
        output pc_wr_en, pc_wr_data, flag_wr_en, flag_wr_data,
        output sb_set_en, sb_set_sel,
        input  rd_a_data, rd_c_data, pc_data, flag_data,
        input  hazard, pending, debug_out
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, rd_b_en, rd_c_sel,
        input  w0_en, w0_sel, w0_data, w0_link,
        input  w1_en, w1_sel, w1_data,
        input  pc_wr_en, pc_wr_data, flag_wr_en, flag_wr_data,
        input  sb_set_en, sb_set_sel,
        output rd_a_data, rd_c_data, pc_data, flag_data,
        output hazard, pending, debug_out
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_mp
// Brief    : Three-read / two-write register bank with PC, link, flags and a
//            load scoreboard. Optional macro REG_BANK_BYPASS_EN enables
//            write-to-read forwarding.
// Revision : 1.0  initial release
// ============================================================================
module reg_bank_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = 15,
    parameter int LR_IDX = 14,
    parameter int FLAG_W = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    reg_bank_mp_if.slave           bus,
    // Tri-state B bus lives outside the interface so it resolves as a net.
    output wire        [DATA_W-1:0] rd_b_data
);
    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC_SEL = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] c_LR_SEL = ADDR_W'(LR_IDX);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [FLAG_W-1:0] r_flags;
    logic [NREGS-1:0]  r_pending;

    logic              w_w0_pc;
    logic              w_w1_pc;
    logic              w_pc_accept;
    logic              w_link;
    logic [ADDR_W-1:0] w_sel [3];
    logic [DATA_W-1:0] w_rd  [3];
    logic [NREGS-1:0]  w_pend_eff;

    assign w_w0_pc     = bus.w0_en && (bus.w0_sel == c_PC_SEL);
    assign w_w1_pc     = bus.w1_en && (bus.w1_sel == c_PC_SEL);
    assign w_pc_accept = bus.pc_wr_en && !w_w0_pc && !w_w1_pc;
    assign w_link      = bus.w0_link && w_w0_pc;

    // Per-register priority: W0, then link into LR, then W1, then PC incrementer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_flags   <= '0;
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.w0_en && (bus.w0_sel == ADDR_W'(i))) begin
                    r_regs[i] <= bus.w0_data;
                end else if (w_link && (ADDR_W'(i) == c_LR_SEL)) begin
                    r_regs[i] <= r_regs[c_PC_SEL];
                end else if (bus.w1_en && (bus.w1_sel == ADDR_W'(i))) begin
                    r_regs[i] <= bus.w1_data;
                end else if (w_pc_accept && (ADDR_W'(i) == c_PC_SEL)) begin
                    r_regs[i] <= bus.pc_wr_data;
                end
            end

            if (bus.flag_wr_en) begin
                r_flags <= bus.flag_wr_data;
            end

            // A new load to the same register outranks the returning one.
            for (int i = 0; i < NREGS; i++) begin
                if (bus.sb_set_en && (bus.sb_set_sel == ADDR_W'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (bus.w1_en && (bus.w1_sel == ADDR_W'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign w_sel[0] = bus.rd_a_sel;
    assign w_sel[1] = bus.rd_b_sel;
    assign w_sel[2] = bus.rd_c_sel;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rd[p] = r_regs[w_sel[p]];
`ifdef REG_BANK_BYPASS_EN
            // Later assignments win: W0 > link > W1 > PC incrementer > storage.
            if (w_pc_accept && (w_sel[p] == c_PC_SEL)) begin
                w_rd[p] = bus.pc_wr_data;
            end
            if (bus.w1_en && (bus.w1_sel == w_sel[p])) begin
                w_rd[p] = bus.w1_data;
            end
            if (w_link && (w_sel[p] == c_LR_SEL)) begin
                w_rd[p] = r_regs[c_PC_SEL];
            end
            if (bus.w0_en && (bus.w0_sel == w_sel[p])) begin
                w_rd[p] = bus.w0_data;
            end
`endif
        end
    end

    always_comb begin
        w_pend_eff = r_pending;
`ifdef REG_BANK_BYPASS_EN
        if (bus.w1_en) begin
            w_pend_eff[bus.w1_sel] = 1'b0;
        end
`endif
    end

    assign bus.rd_a_data = w_rd[0];
    assign bus.rd_c_data = w_rd[2];
    assign rd_b_data     = bus.rd_b_en ? w_rd[1] : {DATA_W{1'bz}};

    assign bus.hazard    = w_pend_eff[bus.rd_a_sel]
                         | (bus.rd_b_en & w_pend_eff[bus.rd_b_sel])
                         | w_pend_eff[bus.rd_c_sel];

    assign bus.pc_data   = r_regs[c_PC_SEL];
    assign bus.flag_data = r_flags;
    assign bus.pending   = r_pending;
    assign bus.debug_out = r_regs[0];
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_mp
// Brief    : Directed self-checking bench for reg_bank_mp.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank_mp;
    logic        clk;
    logic        reset;
    wire  [31:0] rd_b_data;
    int          errors;
    int          checks;

    reg_bank_mp_if #(.DATA_W(32), .ADDR_W(4), .FLAG_W(4)) bus ();

    reg_bank_mp #(
        .DATA_W(32), .ADDR_W(4), .PC_IDX(15), .LR_IDX(14), .FLAG_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rd_b_data (rd_b_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.rd_a_sel     = '0;
        bus.rd_b_sel     = '0;
        bus.rd_b_en      = 1'b0;
        bus.rd_c_sel     = '0;
        bus.w0_en        = 1'b0;
        bus.w0_sel       = '0;
        bus.w0_data      = '0;
        bus.w0_link      = 1'b0;
        bus.w1_en        = 1'b0;
        bus.w1_sel       = '0;
        bus.w1_data      = '0;
        bus.pc_wr_en     = 1'b0;
        bus.pc_wr_data   = '0;
        bus.flag_wr_en   = 1'b0;
        bus.flag_wr_data = '0;
        bus.sb_set_en    = 1'b0;
        bus.sb_set_sel   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.w0_en        = 1'b1;
            bus.w0_sel       = 4'(k);
            bus.w0_data      = $urandom | 32'h1;
            bus.w1_en        = 1'b1;
            bus.w1_sel       = 4'(k + 1);
            bus.w1_data      = $urandom | 32'h1;
            bus.flag_wr_en   = 1'b1;
            bus.flag_wr_data = 4'hF;
            bus.sb_set_en    = 1'b1;
            bus.sb_set_sel   = 4'(k);
            tick();
        end
        bus.pc_wr_en   = 1'b1;
        bus.pc_wr_data = 32'h1234;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        for (int k = 0; k < 16; k++) begin
            bus.rd_a_sel = 4'(k);
            #1;
            checks++;
            if (bus.rd_a_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h expected %h", k, bus.rd_a_data, 32'h0);
            end
        end
        checks++;
        if (bus.pc_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", bus.pc_data, 32'h0);
        end
        checks++;
        if (bus.flag_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags: got %h expected %h", bus.flag_data, 4'h0);
        end
        checks++;
        if (bus.pending !== 16'h0) begin
            errors++;
            $display("FAIL reset_pending: got %h expected %h", bus.pending, 16'h0);
        end
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard: got %b expected %b", bus.hazard, 1'b0);
        end
        checks++;
        if (bus.debug_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_debug: got %h expected %h", bus.debug_out, 32'h0);
        end
    endtask

    task automatic test_same_reg_write();
        idle();
        bus.w0_en = 1'b1; bus.w0_sel = 4'd3; bus.w0_data = 32'h11;
        bus.w1_en = 1'b1; bus.w1_sel = 4'd3; bus.w1_data = 32'h22;
        tick();
        idle();
        bus.rd_a_sel = 4'd3;
        #1;
        checks++;
        if (bus.rd_a_data !== 32'h11) begin
            errors++;
            $display("FAIL w0_beats_w1: got %h expected %h", bus.rd_a_data, 32'h11);
        end
        // W0 must not retire a pending load
        bus.sb_set_en = 1'b1; bus.sb_set_sel = 4'd6;
        tick();
        idle();
        bus.w0_en = 1'b1; bus.w0_sel = 4'd6; bus.w0_data = 32'h66;
        tick();
        idle();
        bus.rd_c_sel = 4'd6;
        #1;
        checks++;
        if (bus.pending !== 16'h0040) begin
            errors++;
            $display("FAIL w0_keeps_pending: got %h expected %h", bus.pending, 16'h0040);
        end
        checks++;
        if (bus.rd_c_data !== 32'h66) begin
            errors++;
            $display("FAIL w0_write_r6: got %h expected %h", bus.rd_c_data, 32'h66);
        end
        bus.w1_en = 1'b1; bus.w1_sel = 4'd6; bus.w1_data = 32'h67;
        tick();
        idle();
        bus.rd_c_sel = 4'd6;
        #1;
        checks++;
        if (bus.pending !== 16'h0000 || bus.rd_c_data !== 32'h67) begin
            errors++;
            $display("FAIL w1_clears_r6: got pending=%h data=%h expected pending=%h data=%h",
                     bus.pending, bus.rd_c_data, 16'h0, 32'h67);
        end
    endtask

    task automatic test_pc_link();
        idle();
        bus.pc_wr_en = 1'b1; bus.pc_wr_data = 32'h100;
        tick();
        idle();
        #1;
        checks++;
        if (bus.pc_data !== 32'h100) begin
            errors++;
            $display("FAIL pc_incr: got %h expected %h", bus.pc_data, 32'h100);
        end
        bus.w0_en = 1'b1; bus.w0_sel = 4'd15; bus.w0_data = 32'h200; bus.w0_link = 1'b1;
        bus.pc_wr_en = 1'b1; bus.pc_wr_data = 32'h104;
        bus.w1_en = 1'b1; bus.w1_sel = 4'd14; bus.w1_data = 32'h999;
        tick();
        idle();
        bus.rd_a_sel = 4'd14;
        #1;
        checks++;
        if (bus.pc_data !== 32'h200) begin
            errors++;
            $display("FAIL bl_pc: got %h expected %h", bus.pc_data, 32'h200);
        end
        checks++;
        if (bus.rd_a_data !== 32'h100) begin
            errors++;
            $display("FAIL bl_lr: got %h expected %h", bus.rd_a_data, 32'h100);
        end
        bus.w1_en = 1'b1; bus.w1_sel = 4'd15; bus.w1_data = 32'h300;
        bus.pc_wr_en = 1'b1; bus.pc_wr_data = 32'h304;
        tick();
        idle();
        #1;
        checks++;
        if (bus.pc_data !== 32'h300) begin
            errors++;
            $display("FAIL w1_beats_pc_incr: got %h expected %h", bus.pc_data, 32'h300);
        end
        bus.w0_en = 1'b1; bus.w0_sel = 4'd2; bus.w0_data = 32'h5; bus.w0_link = 1'b1;
        tick();
        idle();
        bus.rd_a_sel = 4'd14;
        bus.rd_b_en  = 1'b1;
        bus.rd_b_sel = 4'd2;
        #1;
        checks++;
        if (bus.rd_a_data !== 32'h100 || rd_b_data !== 32'h5) begin
            errors++;
            $display("FAIL link_ignored: got lr=%h r2=%h expected lr=%h r2=%h",
                     bus.rd_a_data, rd_b_data, 32'h100, 32'h5);
        end
        idle();
        bus.pc_wr_en = 1'b1; bus.pc_wr_data = 32'h304;
        tick();
        idle();
        #1;
        checks++;
        if (bus.pc_data !== 32'h304) begin
            errors++;
            $display("FAIL pc_incr2: got %h expected %h", bus.pc_data, 32'h304);
        end
    endtask

    task automatic test_flags();
        idle();
        bus.flag_wr_en = 1'b1; bus.flag_wr_data = 4'hA;
        tick();
        idle();
        bus.flag_wr_data = 4'h5;
        bus.w0_en = 1'b1; bus.w0_sel = 4'd1; bus.w0_data = 32'h77;
        tick();
        idle();
        #1;
        checks++;
        if (bus.flag_data !== 4'hA) begin
            errors++;
            $display("FAIL flags_hold: got %h expected %h", bus.flag_data, 4'hA);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        bus.sb_set_en = 1'b1; bus.sb_set_sel = 4'd5;
        tick();
        idle();
        bus.rd_c_sel = 4'd5;
        #1;
        checks++;
        if (bus.hazard !== 1'b1 || bus.pending !== 16'h0020) begin
            errors++;
            $display("FAIL sb_hazard_c: got hazard=%b pending=%h expected hazard=1 pending=%h",
                     bus.hazard, bus.pending, 16'h0020);
        end
        bus.rd_c_sel = 4'd0;
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL sb_no_hazard: got %b expected %b", bus.hazard, 1'b0);
        end
        bus.rd_c_sel = 4'd5;
        bus.w1_en = 1'b1; bus.w1_sel = 4'd5; bus.w1_data = 32'hAB;
        #1;
`ifdef REG_BANK_BYPASS_EN
        checks++;
        if (bus.hazard !== 1'b0 || bus.rd_c_data !== 32'hAB) begin
            errors++;
            $display("FAIL sb_bypass_clear: got hazard=%b data=%h expected hazard=0 data=%h",
                     bus.hazard, bus.rd_c_data, 32'hAB);
        end
`else
        checks++;
        if (bus.hazard !== 1'b1 || bus.rd_c_data !== 32'h0) begin
            errors++;
            $display("FAIL sb_pre_clear: got hazard=%b data=%h expected hazard=1 data=%h",
                     bus.hazard, bus.rd_c_data, 32'h0);
        end
`endif
        tick();
        idle();
        bus.rd_c_sel = 4'd5;
        #1;
        checks++;
        if (bus.hazard !== 1'b0 || bus.rd_c_data !== 32'hAB) begin
            errors++;
            $display("FAIL sb_cleared: got hazard=%b data=%h expected hazard=0 data=%h",
                     bus.hazard, bus.rd_c_data, 32'hAB);
        end
        // Same-edge set is not visible to hazard until the next cycle
        bus.rd_a_sel = 4'd9;
        bus.sb_set_en = 1'b1; bus.sb_set_sel = 4'd9;
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL sb_set_not_same_cycle: got %b expected %b", bus.hazard, 1'b0);
        end
        tick();
        idle();
        bus.w1_en = 1'b1; bus.w1_sel = 4'd9; bus.w1_data = 32'h99;
        tick();
        idle();
        bus.sb_set_en = 1'b1; bus.sb_set_sel = 4'd5;
        bus.w1_en = 1'b1; bus.w1_sel = 4'd5; bus.w1_data = 32'hCD;
        tick();
        idle();
        bus.rd_c_sel = 4'd5;
        #1;
        checks++;
        if (bus.pending !== 16'h0020 || bus.rd_c_data !== 32'hCD) begin
            errors++;
            $display("FAIL sb_set_and_clear: got pending=%h data=%h expected pending=%h data=%h",
                     bus.pending, bus.rd_c_data, 16'h0020, 32'hCD);
        end
    endtask

    task automatic test_port_b();
        idle();
        bus.rd_b_sel = 4'd3;
        bus.rd_b_en  = 1'b0;
        #1;
        // A two-state simulator resolves the floating bus to zero; either is released.
        checks++;
        if (rd_b_data !== {32{1'bz}} && rd_b_data !== 32'h0) begin
            errors++;
            $display("FAIL b_released: got %h expected %h", rd_b_data, {32{1'bz}});
        end
        bus.rd_b_en = 1'b1;
        #1;
        checks++;
        if (rd_b_data !== 32'h11) begin
            errors++;
            $display("FAIL b_drive: got %h expected %h", rd_b_data, 32'h11);
        end
        bus.rd_b_sel = 4'd5;
        bus.rd_b_en  = 1'b0;
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL b_hazard_off: got %b expected %b", bus.hazard, 1'b0);
        end
        bus.rd_b_en = 1'b1;
        #1;
        checks++;
        if (bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL b_hazard_on: got %b expected %b", bus.hazard, 1'b1);
        end
        idle();
        bus.w1_en = 1'b1; bus.w1_sel = 4'd5; bus.w1_data = 32'hEE;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        idle();
        bus.rd_a_sel = 4'd7;
        bus.w0_en = 1'b1; bus.w0_sel = 4'd7; bus.w0_data = 32'h5A5A;
        #1;
`ifdef REG_BANK_BYPASS_EN
        checks++;
        if (bus.rd_a_data !== 32'h5A5A) begin
            errors++;
            $display("FAIL fwd_w0: got %h expected %h", bus.rd_a_data, 32'h5A5A);
        end
`else
        checks++;
        if (bus.rd_a_data !== 32'h0) begin
            errors++;
            $display("FAIL no_fwd_w0: got %h expected %h", bus.rd_a_data, 32'h0);
        end
`endif
        tick();
        idle();
        bus.rd_a_sel = 4'd7;
        #1;
        checks++;
        if (bus.rd_a_data !== 32'h5A5A) begin
            errors++;
            $display("FAIL r7_stored: got %h expected %h", bus.rd_a_data, 32'h5A5A);
        end
        bus.rd_b_en = 1'b1; bus.rd_b_sel = 4'd15;
        bus.pc_wr_en = 1'b1; bus.pc_wr_data = 32'h400;
        #1;
`ifdef REG_BANK_BYPASS_EN
        checks++;
        if (rd_b_data !== 32'h400) begin
            errors++;
            $display("FAIL fwd_pc: got %h expected %h", rd_b_data, 32'h400);
        end
`else
        checks++;
        if (rd_b_data !== 32'h304) begin
            errors++;
            $display("FAIL no_fwd_pc: got %h expected %h", rd_b_data, 32'h304);
        end
`endif
        tick();
        idle();
        bus.w0_en = 1'b1; bus.w0_sel = 4'd0; bus.w0_data = 32'hDEAD;
        tick();
        idle();
        #1;
        checks++;
        if (bus.debug_out !== 32'hDEAD || bus.pc_data !== 32'h400) begin
            errors++;
            $display("FAIL debug_and_pc: got dbg=%h pc=%h expected dbg=%h pc=%h",
                     bus.debug_out, bus.pc_data, 32'hDEAD, 32'h400);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_same_reg_write();
        test_pc_link();
        test_flags();
        test_scoreboard();
        test_port_b();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
